// File: rtl/sha256_job_arbiter_if.sv
// Requester- and core-facing bus of sha256_job_arbiter.
// master: the arbiter; slave: requesters plus the hashing core.
interface sha256_job_arbiter_if #(
    parameter int NUM_REQ = 4
);
    // Handshake: req[i] is a level held until ack[i]; grant is one-hot ownership of
    // the core; ack[i] is a one-cycle completion pulse; core_start is a one-cycle
    // pulse; core_done is a level that is high whenever the core is idle.
    logic [NUM_REQ-1:0]    req;
    logic [16*NUM_REQ-1:0] req_msg_addr;
    logic [16*NUM_REQ-1:0] req_out_addr;
    logic [NUM_REQ-1:0]    grant;
    logic [NUM_REQ-1:0]    ack;
    logic                  core_start;
    logic [15:0]           core_message_addr;
    logic [15:0]           core_output_addr;
    logic                  core_done;

    modport master (
        input  req, req_msg_addr, req_out_addr, core_done,
        output grant, ack, core_start, core_message_addr, core_output_addr
    );

    modport slave (
        output req, req_msg_addr, req_out_addr, core_done,
        input  grant, ack, core_start, core_message_addr, core_output_addr
    );
endinterface

// File: rtl/sha256_job_arbiter.sv
// Round-robin arbiter sharing one SHA-256 core among NUM_REQ requesters.
// Optional job watchdog with err/core_abort outputs: define SHA256_ARB_TIMEOUT_EN.
module sha256_job_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                        clk,
    input  logic                        reset_n,
    sha256_job_arbiter_if.master        bus,
    output logic                        busy_o,
    output logic [15:0]                 job_count_o,
`ifdef SHA256_ARB_TIMEOUT_EN
    output logic                        err_o,
    output logic                        core_abort_o,
`endif
    output logic [2:0]                  state_o
);
    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_LOW  = 3'd2,
        WAIT_HIGH = 3'd3,
        ACK       = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;
    logic [15:0]        msg_q, msg_d;
    logic [15:0]        out_q, out_d;
    logic [15:0]        jc_q, jc_d;

    logic               found;
    logic [PTR_W-1:0]   winner;
    logic               done_ok;
    logic               timed_out;

    // First requester at or after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        logic [PTR_W:0]   idx;
        logic [PTR_W-1:0] cand;
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (idx >= (PTR_W+1)'(NUM_REQ)) idx = idx - (PTR_W+1)'(NUM_REQ);
            cand = idx[PTR_W-1:0];
            if (!found && bus.req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign done_ok = (state_q == WAIT_HIGH) && bus.core_done;

`ifdef SHA256_ARB_TIMEOUT_EN
    logic [15:0] wdog_q, wdog_d;
    logic        err_q, err_d;
    logic        abort_q, abort_d;

    // A normal completion in the same cycle takes priority over the watchdog.
    assign timed_out = ((state_q == WAIT_LOW) || (state_q == WAIT_HIGH)) && !done_ok &&
                       (wdog_q == 16'(TIMEOUT_CYCLES - 1));
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        grant_d = grant_q;
        ack_d   = '0;
        start_d = 1'b0;
        msg_d   = msg_q;
        out_d   = out_q;
        jc_d    = jc_q;
`ifdef SHA256_ARB_TIMEOUT_EN
        wdog_d  = wdog_q;
        err_d   = 1'b0;
        abort_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (found && bus.core_done) begin
                    owner_d = winner;
                    grant_d = NUM_REQ'(1) << winner;
                    msg_d   = bus.req_msg_addr[{winner, 4'b0000} +: 16];
                    out_d   = bus.req_out_addr[{winner, 4'b0000} +: 16];
                    start_d = 1'b1;
                    state_d = ISSUE;
`ifdef SHA256_ARB_TIMEOUT_EN
                    wdog_d  = '0;
`endif
                end
            end
            ISSUE:     state_d = WAIT_LOW;
            WAIT_LOW:  if (!bus.core_done) state_d = WAIT_HIGH;
            WAIT_HIGH: ;
            ACK:       state_d = IDLE;
            default:   state_d = IDLE;
        endcase

`ifdef SHA256_ARB_TIMEOUT_EN
        if ((state_q == WAIT_LOW) || (state_q == WAIT_HIGH)) wdog_d = wdog_q + 16'd1;
        err_d   = timed_out;
        abort_d = timed_out;
`endif

        if (done_ok || timed_out) begin
            ack_d   = grant_q;
            grant_d = '0;
            ptr_d   = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
            state_d = ACK;
            if (done_ok) jc_d = jc_q + 16'd1;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            msg_q   <= '0;
            out_q   <= '0;
            jc_q    <= '0;
`ifdef SHA256_ARB_TIMEOUT_EN
            wdog_q  <= '0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            msg_q   <= msg_d;
            out_q   <= out_d;
            jc_q    <= jc_d;
`ifdef SHA256_ARB_TIMEOUT_EN
            wdog_q  <= wdog_d;
            err_q   <= err_d;
            abort_q <= abort_d;
`endif
        end
    end

    assign bus.grant             = grant_q;
    assign bus.ack               = ack_q;
    assign bus.core_start        = start_q;
    assign bus.core_message_addr = msg_q;
    assign bus.core_output_addr  = out_q;
    assign busy_o                = busy_q;
    assign job_count_o           = jc_q;
    assign state_o               = state_q;
`ifdef SHA256_ARB_TIMEOUT_EN
    assign err_o                 = err_q;
    assign core_abort_o          = abort_q;
`endif
endmodule

// File: doc/sha256_job_arbiter.md
Name: sha256_job_arbiter

Overview:
Shares one simplified SHA-256 hashing core among NUM_REQ requesters, for example several nonce workers in the bitcoin hashing top level.
- Arbitrates round-robin and latches the winner's message and output addresses.
- Pulses the core's start, tracks the core's level-type done through a full job, and returns a one-cycle ack to the winner.
- Sits between the requesters and the core's start, message_addr, output_addr and done pins.
- The core keeps its own memory port; this block does not touch memory.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
TIMEOUT_CYCLES, 4096, watchdog limit in cycles per job (used only with the optional feature).

Ports:
clk  in  1  clock.
reset_n  in  1  reset; asynchronous, active-low.
req  in  NUM_REQ  per-requester job request, level; held until matching ack.
req_msg_addr  in  16*NUM_REQ  message base address; slice i = bits [16*i+15:16*i].
req_out_addr  in  16*NUM_REQ  hash output base address, same slicing.
grant  out  NUM_REQ  one-hot owner of the core; 0 when idle.
ack  out  NUM_REQ  one-cycle pulse on the owner's bit when its hash is written.
busy  out  1  high in every state except IDLE.
job_count  out  16  completed jobs, wraps 0xFFFF->0x0000.
core_start  out  1  start to the core; one-cycle pulse.
core_message_addr  out  16  latched message address of the owner.
core_output_addr  out  16  latched output address of the owner.
core_done  in  1  core done; high whenever the core is in IDLE.

Behaviour:
- Reset values: all outputs 0; rr pointer 0; state IDLE. Reset mid-job returns to IDLE immediately and issues no ack. Resetting the core is the integrator's job.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, ACK.
- IDLE: if (req != 0) and core_done == 1:
  - Pick the first set req bit at or after the pointer, modulo NUM_REQ.
  - Set grant one-hot and latch that requester's two addresses into core_*_addr.
  - Go to ISSUE.
  - If core_done == 0, wait in IDLE; nothing is granted.
- ISSUE: core_start = 1 for exactly this cycle; go to WAIT_LOW.
- WAIT_LOW: stay until core_done == 0, meaning the core has left IDLE; then go to WAIT_HIGH.
  - A start-to-done-low gap of 1 cycle is the nominal case; any gap is tolerated.
- WAIT_HIGH: stay until core_done == 1; then go to ACK.
- ACK, one cycle:
  - ack[owner] = 1 and grant cleared.
  - Pointer = (owner+1) mod NUM_REQ.
  - job_count increments.
  - Go to IDLE.
- Latency: req sampled high in IDLE -> grant at next edge -> core_start during the following cycle. Arbitration overhead is 3 cycles per job plus the core time. Back-to-back jobs: the next grant occurs the cycle after ACK.
- core_*_addr hold their value after ACK until the next grant. A req or address change while granted has no effect.
- req dropped before ack: the job still completes and ack still pulses. The requester must ignore it.
- Simultaneous requests are resolved strictly round-robin, so no requester waits more than NUM_REQ-1 jobs.
- A req bit for requester i that is still high in the cycle after ack[i] counts as a new request.

Optional Feature:
Macro SHA256_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog counter clears on entry to ISSUE and counts in WAIT_LOW and WAIT_HIGH.
  - If it reaches TIMEOUT_CYCLES, go to ACK with extra output err (1 bit, reset 0) = 1 alongside the ack pulse, plus output core_abort (1 bit, reset 0) = 1 for one cycle. core_abort is intended to drive the core's reset.
  - job_count does not increment on a timed-out job.
- Undefined: no counter, no err or core_abort ports, and no timeout; the block waits indefinitely.

Test Plan:
1. Single job: req=4'b0010, addr1=0x0000/0x0100, core model done-low 1 cycle after start for 200 cycles -> grant=0010 next edge, core_start one cycle with core_message_addr=0x0000 and core_output_addr=0x0100, ack[1] pulse 1 cycle after done rises, job_count=1.
2. All four requesting from reset, req=1111 held -> grant order 0,1,2,3,0; each ack on the matching bit; job_count=4 after the fourth ack.
3. Core not idle: core_done=0 while req=0001 -> no grant and no core_start until core_done=1; then grant=0001.
4. Dropped request: req[2] deasserted during WAIT_HIGH -> job completes, ack[2] still pulses, pointer moves to 3.
5. Reset mid-job: reset_n low during WAIT_HIGH -> all outputs 0 and no ack; after release, req=0100 is granted with the pointer starting at 0.
6. With SHA256_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=50, core_done stuck 0 -> at cycle 50, ack[owner]=1, err=1 and core_abort=1 for one cycle, and job_count unchanged.
